// File: rtl/ad9833_sweep_ctrl.sv
// Frequency-sweep sequencer for the AD9833 word interface (go/control/freq).
// Arms the DDS, steps start..stop with a per-step dwell, then mutes.
module ad9833_sweep_ctrl #(
    parameter logic [15:0] CTRL_RUN   = 16'h2000,
    parameter logic [15:0] CTRL_MUTE  = 16'h2100,
    parameter int          DWELL_W    = 32,
    parameter int          HS_TIMEOUT = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_continuous,
    input  logic [27:0]        i_start_freq,
    input  logic [27:0]        i_stop_freq,
    input  logic [27:0]        i_step_freq,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic               o_go,
    output logic [15:0]        o_control,
    output logic [27:0]        o_freq,
    input  logic               i_good_to_reset_go,
    input  logic               i_send_complete,
    output logic               o_busy,
    output logic               o_sweep_done,
    output logic               o_error,
    output logic [27:0]        o_cur_freq
);

    localparam int TW = $clog2(HS_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_LOAD, S_DWELL, S_STEP, S_MUTE
    } state_t;

    state_t             state;
    logic [27:0]        start_q;
    logic [27:0]        stop_q;
    logic [27:0]        step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               cont_q;
    logic [27:0]        cur;
    logic               acked;
    logic               aborted;
    logic [TW-1:0]      timer;
    logic [DWELL_W-1:0] dcnt;

    logic [28:0] sum;
    logic        sweep_end;
    logic        timed_out;
    logic        last_dwell;
    logic        abort_any;

    assign sum        = {1'b0, cur} + {1'b0, step_q};
    assign sweep_end  = sum[28] || (sum[27:0] > stop_q);
    assign timed_out  = (timer == TW'(HS_TIMEOUT - 1));
    assign last_dwell = (dwell_q == '0) || (dcnt == dwell_q - DWELL_W'(1));
    assign abort_any  = aborted || i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            start_q      <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            cont_q       <= 1'b0;
            cur          <= '0;
            acked        <= 1'b0;
            aborted      <= 1'b0;
            timer        <= '0;
            dcnt         <= '0;
            o_go         <= 1'b0;
            o_control    <= CTRL_MUTE;
            o_freq       <= '0;
            o_busy       <= 1'b0;
            o_sweep_done <= 1'b0;
            o_error      <= 1'b0;
            o_cur_freq   <= '0;
        end else begin
            o_sweep_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        start_q <= i_start_freq;
                        stop_q  <= i_stop_freq;
                        step_q  <= i_step_freq;
                        dwell_q <= i_dwell;
                        cont_q  <= i_continuous;
                        cur     <= i_start_freq;
                        aborted <= 1'b0;
                        acked   <= 1'b0;
                        timer   <= '0;
                        if (i_step_freq == '0 || i_start_freq > i_stop_freq) begin
                            o_error <= 1'b1;
                        end else begin
                            o_error   <= 1'b0;
                            o_busy    <= 1'b1;
                            o_go      <= 1'b1;
                            o_control <= CTRL_MUTE;
                            o_freq    <= i_start_freq;
                            state     <= S_ARM;
                        end
                    end
                end
                S_ARM, S_LOAD, S_MUTE: begin
                    if (i_abort) aborted <= 1'b1;
                    if (!o_go && !acked) begin
                        o_go      <= 1'b1;
                        o_control <= (state == S_LOAD) ? CTRL_RUN : CTRL_MUTE;
                        o_freq    <= cur;
                        timer     <= '0;
                    end else if (o_go) begin
                        if (i_good_to_reset_go) begin
                            o_go  <= 1'b0;
                            acked <= 1'b1;
                            timer <= '0;
                        end else if (timed_out) begin
                            o_go    <= 1'b0;
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end else if (i_send_complete) begin
                        acked <= 1'b0;
                        timer <= '0;
                        if (state == S_ARM) begin
                            state <= abort_any ? S_MUTE : S_LOAD;
                        end else if (state == S_LOAD) begin
                            o_cur_freq <= cur;
                            dcnt       <= '0;
                            state      <= abort_any ? S_MUTE : S_DWELL;
                        end else begin
                            o_busy       <= 1'b0;
                            o_sweep_done <= !abort_any;
                            state        <= S_IDLE;
                        end
                    end else if (timed_out) begin
                        acked   <= 1'b0;
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DWELL: begin
                    if (i_abort) begin
                        aborted <= 1'b1;
                        state   <= S_MUTE;
                    end else if (last_dwell) begin
                        state <= S_STEP;
                    end else begin
                        dcnt <= dcnt + DWELL_W'(1);
                    end
                end
                S_STEP: begin
                    if (i_abort) begin
                        aborted <= 1'b1;
                        state   <= S_MUTE;
                    end else if (sweep_end) begin
                        // wrap restarts at the latched start, never at the overflowed sum
                        if (cont_q) begin
                            cur   <= start_q;
                            state <= S_LOAD;
                        end else begin
                            state <= S_MUTE;
                        end
                    end else begin
                        cur   <= sum[27:0];
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// Self-checking bench for ad9833_sweep_ctrl with a simple ad9833if model
// (ack 2 cycles after go, completion 34 cycles after go).
module tb_ad9833_sweep_ctrl;

    localparam int HS = 1024;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cont;
    logic [27:0] start_freq;
    logic [27:0] stop_freq;
    logic [27:0] step_freq;
    logic [31:0] dwell;
    logic        go;
    logic [15:0] control;
    logic [27:0] freq;
    logic        ack;
    logic        cmpl;
    logic        busy;
    logic        sweep_done;
    logic        err;
    logic [27:0] cur_freq;

    ad9833_sweep_ctrl #(.HS_TIMEOUT(HS)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_abort(abort),
        .i_continuous(cont),
        .i_start_freq(start_freq),
        .i_stop_freq(stop_freq),
        .i_step_freq(step_freq),
        .i_dwell(dwell),
        .o_go(go),
        .o_control(control),
        .o_freq(freq),
        .i_good_to_reset_go(ack),
        .i_send_complete(cmpl),
        .o_busy(busy),
        .o_sweep_done(sweep_done),
        .o_error(err),
        .o_cur_freq(cur_freq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ad9833if model
    bit ack_en;
    bit active;
    int mcnt;
    initial begin
        ack = 1'b0;
        cmpl = 1'b0;
        active = 0;
        mcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            cmpl = 1'b0;
            if (!rst_n) begin
                active = 0;
            end else if (active) begin
                mcnt++;
            end else if (go && ack_en) begin
                active = 1;
                mcnt = 0;
            end
            ack = active && go && (mcnt >= 2);
            if (active && mcnt == 34) begin
                cmpl = 1'b1;
                active = 0;
            end
        end
    end

    // transaction log and protocol monitors
    logic [43:0] log_q[$];
    logic [43:0] prev_cf;
    logic        prev_go = 1'b0;
    logic        prev_busy = 1'b0;
    logic        ack_at_edge = 1'b0;
    bit          tmo_mode = 0;
    bit          busy_seen;
    int          done_cnt, stab_bad, early, busy_bad, go_hi_cnt;

    always @(posedge clk) ack_at_edge = ack;

    always @(negedge clk) begin
        if (go && !prev_go) log_q.push_back({control, freq});
        if (go && prev_go && {control, freq} != prev_cf) stab_bad++;
        if (!go && prev_go && !ack_at_edge && !tmo_mode && rst_n) early++;
        if (go) go_hi_cnt++;
        if (busy) busy_seen = 1;
        if (sweep_done) begin
            done_cnt++;
            if (busy || !prev_busy) busy_bad++;
        end
        prev_go = go;
        prev_cf = {control, freq};
        prev_busy = busy;
    end

    task automatic clear_mon();
        log_q.delete();
        done_cnt = 0;
        stab_bad = 0;
        early = 0;
        busy_bad = 0;
        go_hi_cnt = 0;
        busy_seen = 0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", busy, 0);
    endtask

    task automatic kick(input logic [27:0] s, input logic [27:0] e,
                        input logic [27:0] st, input logic [31:0] d,
                        input logic c);
        @(negedge clk);
        start_freq = s;
        stop_freq = e;
        step_freq = st;
        dwell = d;
        cont = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic [27:0] s;
        logic [27:0] e;
        logic [27:0] st;
        logic [31:0] d;
        logic        err;
        int          nloads;
        logic [27:0] last;
    } vec_t;

    vec_t vt[7];

    task automatic run_vec(input vec_t v, input int idx);
        logic [27:0] f;
        string tag;
        tag = $sformatf("v%0d", idx);
        clear_mon();
        kick(v.s, v.e, v.st, v.d, 1'b0);
        if (v.err) begin
            check({tag, "_err_now"}, err, 1);
            repeat (5) @(negedge clk);
            check({tag, "_no_go"}, log_q.size(), 0);
            check({tag, "_no_busy"}, busy_seen, 0);
            check({tag, "_err_hold"}, err, 1);
            return;
        end
        check({tag, "_go_lat"}, go, 1);
        check({tag, "_err_clr"}, err, 0);
        // config changes and a second start while busy must be ignored
        start_freq = 28'h1234;
        stop_freq = 28'hFFFFFFF;
        step_freq = 28'h1;
        dwell = 32'd0;
        cont = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(3000);
        repeat (3) @(negedge clk);
        check({tag, "_ntrans"}, log_q.size(), v.nloads + 2);
        if (log_q.size() == v.nloads + 2) begin
            check({tag, "_arm"}, log_q[0], {16'h2100, v.s});
            f = v.s;
            for (int k = 0; k < v.nloads; k++) begin
                check($sformatf("%s_load%0d", tag, k), log_q[k + 1], {16'h2000, f});
                f = f + v.st;
            end
            check({tag, "_mute"}, log_q[v.nloads + 1], {16'h2100, v.last});
        end
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_busyfall"}, busy_bad, 0);
        check({tag, "_cur"}, cur_freq, v.last);
        check({tag, "_err"}, err, 0);
        check({tag, "_stable"}, stab_bad, 0);
        check({tag, "_early"}, early, 0);
    endtask

    initial begin
        vt[0] = '{s:28'h0F0, e:28'h2D0, st:28'h0F0, d:32'd4,
                  err:1'b0, nloads:3, last:28'h2D0};
        vt[1] = '{s:28'hFFFFFF0, e:28'hFFFFFFF, st:28'h20, d:32'd2,
                  err:1'b0, nloads:1, last:28'hFFFFFF0};
        vt[2] = '{s:28'h100, e:28'h100, st:28'h1, d:32'd0,
                  err:1'b0, nloads:1, last:28'h100};
        vt[3] = '{s:28'h100, e:28'h150, st:28'h30, d:32'd1,
                  err:1'b0, nloads:2, last:28'h130};
        vt[4] = '{s:28'h100, e:28'h200, st:28'h0, d:32'd1,
                  err:1'b1, nloads:0, last:28'h0};
        vt[5] = '{s:28'h200, e:28'h100, st:28'h10, d:32'd1,
                  err:1'b1, nloads:0, last:28'h0};
        vt[6] = '{s:28'h0, e:28'hFFFFFFF, st:28'h8000000, d:32'd3,
                  err:1'b0, nloads:2, last:28'h8000000};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cont = 1'b0;
        start_freq = '0;
        stop_freq = '0;
        step_freq = '0;
        dwell = '0;
        ack_en = 1;
        repeat (3) @(negedge clk);
        check("rst_go", go, 0);
        check("rst_ctrl", control, 16'h2100);
        check("rst_freq", freq, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_cur", cur_freq, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // continuous wrap, then abort in a dwell
        clear_mon();
        kick(28'h0F0, 28'h2D0, 28'h0F0, 32'd4, 1'b1);
        for (int n = 0; n < 2000 && log_q.size() < 5; n++) @(negedge clk);
        for (int n = 0; n < 100 && !cmpl; n++) @(negedge clk);
        check("cont_cmpl_seen", cmpl, 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle(1000);
        repeat (3) @(negedge clk);
        check("cont_ntrans", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("cont_t3", log_q[3], {16'h2000, 28'h2D0});
            check("cont_wrap", log_q[4], {16'h2000, 28'h0F0});
            check("cont_mute", log_q[5], {16'h2100, 28'h0F0});
        end
        check("cont_done", done_cnt, 0);
        check("cont_err", err, 0);

        // abort while go is high, before the ack
        clear_mon();
        kick(28'h0F0, 28'h2D0, 28'h0F0, 32'd4, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abgo_held", go, 1);
        wait_idle(1000);
        repeat (3) @(negedge clk);
        check("abgo_ntrans", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("abgo_arm", log_q[0], {16'h2100, 28'h0F0});
            check("abgo_mute", log_q[1], {16'h2100, 28'h0F0});
        end
        check("abgo_done", done_cnt, 0);
        check("abgo_err", err, 0);
        check("abgo_early", early, 0);

        // async reset in the middle of a dwell
        clear_mon();
        kick(28'h0F0, 28'h2D0, 28'h0F0, 32'd4, 1'b0);
        for (int n = 0; n < 500 && cur_freq != 28'h0F0; n++) @(negedge clk);
        check("rst_mid_reach", cur_freq, 28'h0F0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstm_go", go, 0);
        check("rstm_busy", busy, 0);
        check("rstm_ctrl", control, 16'h2100);
        check("rstm_freq", freq, 0);
        check("rstm_cur", cur_freq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // handshake timeout, no ack ever
        clear_mon();
        ack_en = 0;
        tmo_mode = 1;
        kick(28'h0F0, 28'h2D0, 28'h0F0, 32'd4, 1'b0);
        wait_idle(HS + 200);
        repeat (3) @(negedge clk);
        check("tmo_go_cycles", go_hi_cnt, HS);
        check("tmo_go", go, 0);
        check("tmo_err", err, 1);
        check("tmo_ntrans", log_q.size(), 1);
        ack_en = 1;
        tmo_mode = 0;
        run_vec(vt[0], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
